seq_checker: RTL and testbench

Receive-side checker for the 16-bit repeating test pattern produced by the pattern generator and carried through the Costas carrier-recovery loop. It runs on the bit-rate clock clk_flag and takes the recovered hard-decision bit. It searches all 16 rotations of the pattern and their complements, so it resolves both frame alignment and the Costas 180° phase ambiguity. Once aligned it verifies, then holds lock while reporting bit errors, a saturating error count, phase-corrected data and frame boundaries.

---
 rtl/seq_pkg.sv | 30 +++
 rtl/seq_checker_if.sv | 25 ++
 rtl/seq_pattern_match.sv | 46 ++++
 rtl/seq_checker.sv | 159 +++++++++++++++
 tb/tb_seq_checker.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// Shared constants for the pattern checker: reference pattern, state codes, widths
// and the rotation helper used by the pattern matcher.
package seq_pkg;

   localparam int PAT_LEN = 16;
   localparam int PHASE_W = 4;
   localparam int ERR_W   = 16;
   localparam int CNT_W   = 5;

   localparam logic [PAT_LEN-1:0] PATTERN_DEF = 16'hCBB2;

   typedef logic [1:0] state_t;
   localparam state_t SEARCH = 2'd0;
   localparam state_t VERIFY = 2'd1;
   localparam state_t LOCK   = 2'd2;

   // Window image of rotation r: the oldest bit (msb) is pattern[r], the newest is pattern[r+15].
   function automatic logic [PAT_LEN-1:0] rotate_ref(input logic [PAT_LEN-1:0] pattern,
                                                     input logic [PHASE_W-1:0] r);
      logic [PAT_LEN-1:0] ref_w;
      logic [PHASE_W-1:0] idx;
      ref_w = '0;
      for (int j = 0; j < PAT_LEN; j++) begin
         idx                 = r + PHASE_W'(j);
         ref_w[PAT_LEN-1-j]  = pattern[idx];
      end
      return ref_w;
   endfunction

endpackage

// File: rtl/seq_checker_if.sv
// Receive-side bit and status bundle of the pattern checker.
interface seq_checker_if;
   import seq_pkg::*;

   logic               rx_bit;
   logic               err_clr;
   logic               locked;
   logic               inverted;
   logic [PHASE_W-1:0] phase;
   logic               data_out;
   logic               bit_err;
   logic               frame_start;
   logic [ERR_W-1:0]   err_cnt;

   modport master (
      output rx_bit, err_clr,
      input  locked, inverted, phase, data_out, bit_err, frame_start, err_cnt
   );

   modport slave (
      input  rx_bit, err_clr,
      output locked, inverted, phase, data_out, bit_err, frame_start, err_cnt
   );

endinterface

// File: rtl/seq_pattern_match.sv
// Compares a 16-bit window against all rotations of the pattern and its complement;
// normal polarity wins over inverted, then the lowest rotation wins.
module seq_pattern_match
   import seq_pkg::*;
(
   input  logic [PAT_LEN-1:0] win,
   input  logic [PAT_LEN-1:0] pattern,
   output logic               hit,
   output logic               hit_inv,
   output logic [PHASE_W-1:0] hit_phase
);

   logic [PAT_LEN-1:0] eq_norm;
   logic [PAT_LEN-1:0] eq_inv;

   always_comb begin
      eq_norm = '0;
      eq_inv  = '0;
      for (int r = 0; r < PAT_LEN; r++) begin
         eq_norm[r] = (win ==  rotate_ref(pattern, PHASE_W'(r)));
         eq_inv[r]  = (win == ~rotate_ref(pattern, PHASE_W'(r)));
      end
   end

   // Later assignments override earlier ones, so scan from low to high priority.
   always_comb begin
      hit       = 1'b0;
      hit_inv   = 1'b0;
      hit_phase = '0;
      for (int r = PAT_LEN-1; r >= 0; r--) begin
         if (eq_inv[r]) begin
            hit       = 1'b1;
            hit_inv   = 1'b1;
            hit_phase = PHASE_W'(r);
         end
      end
      for (int r = PAT_LEN-1; r >= 0; r--) begin
         if (eq_norm[r]) begin
            hit       = 1'b1;
            hit_inv   = 1'b0;
            hit_phase = PHASE_W'(r);
         end
      end
   end

endmodule

// File: rtl/seq_checker.sv
// Pattern checker: acquires alignment and polarity of the repeating test pattern,
// verifies it, then tracks bit errors and frame boundaries while locked.
//
//   state  | meaning
//   SEARCH | hunting all rotations/polarities in the last 16 bits
//   VERIFY | aligned; counting consecutive clean bits before declaring lock
//   LOCK   | locked; reporting errors, dropping lock on a bad frame
module seq_checker
   import seq_pkg::*;
#(
   parameter logic [PAT_LEN-1:0] PATTERN    = PATTERN_DEF,
   parameter int                 VERIFY_LEN = 16,
   parameter int                 LOSS_THR   = 4
) (
   input logic          clk_flag,
   input logic          sys_rst_n,
   seq_checker_if.slave bus
);

   localparam logic [CNT_W-1:0] VLEN = CNT_W'(VERIFY_LEN);
   localparam logic [CNT_W-1:0] LTHR = CNT_W'(LOSS_THR);

   state_t             state;
   state_t             state_nxt;
   logic [PAT_LEN-2:0] sr;
   logic [PAT_LEN-1:0] win;
   logic [PHASE_W-1:0] fill_cnt;
   logic [PHASE_W-1:0] ptr;
   logic               inv;
   logic [CNT_W-1:0]   vcnt;
   logic [CNT_W-1:0]   frame_err;
   logic [CNT_W-1:0]   frame_tot;
   logic [ERR_W-1:0]   err_cnt;

   logic               hit;
   logic               hit_inv;
   logic [PHASE_W-1:0] hit_phase;
   logic               fill_full;
   logic               mis;
   logic               frame_end;

   logic               locked_q;
   logic               data_q;
   logic               bit_err_q;
   logic               frame_start_q;
   logic               locked_d;
   logic               data_d;
   logic               bit_err_d;
   logic               frame_start_d;

   assign win       = {sr, bus.rx_bit};
   assign fill_full = (fill_cnt == '1);
   assign mis       = bus.rx_bit ^ (PATTERN[ptr] ^ inv);
   assign frame_end = (ptr == '1);
   assign frame_tot = frame_err + CNT_W'(mis);

   seq_pattern_match u_match (
      .win       (win),
      .pattern   (PATTERN),
      .hit       (hit),
      .hit_inv   (hit_inv),
      .hit_phase (hit_phase)
   );

   always_ff @(posedge clk_flag or negedge sys_rst_n) begin
      if (!sys_rst_n) state <= SEARCH;
      else            state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         SEARCH: if (fill_full && hit) state_nxt = VERIFY;
         VERIFY: begin
            if (mis)                     state_nxt = SEARCH;
            else if (vcnt + 1'b1 == VLEN) state_nxt = LOCK;
         end
         LOCK:   if (frame_end && frame_tot >= LTHR) state_nxt = SEARCH;
         default: state_nxt = SEARCH;
      endcase
   end

   always_comb begin
      locked_d      = (state_nxt == LOCK);
      data_d        = bus.rx_bit ^ inv;
      bit_err_d     = (state == LOCK) && mis;
      frame_start_d = (state == LOCK) && (ptr == '0);
   end

   always_ff @(posedge clk_flag or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sr        <= '0;
         fill_cnt  <= '0;
         ptr       <= '0;
         inv       <= 1'b0;
         vcnt      <= '0;
         frame_err <= '0;
      end else begin
         sr <= win[PAT_LEN-2:0];
         if (!fill_full) fill_cnt <= fill_cnt + 1'b1;
         case (state)
            SEARCH: begin
               if (fill_full && hit) begin
                  ptr  <= hit_phase;
                  inv  <= hit_inv;
                  vcnt <= '0;
               end
            end
            VERIFY: begin
               if (!mis) begin
                  ptr  <= ptr + 1'b1;
                  vcnt <= vcnt + 1'b1;
                  if (vcnt + 1'b1 == VLEN) frame_err <= '0;
               end
            end
            LOCK: begin
               ptr <= ptr + 1'b1;
               // The frame tally restarts on every frame boundary whether or not lock survives.
               if (frame_end) frame_err <= '0;
               else           frame_err <= frame_tot;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_flag or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         err_cnt <= '0;
      end else if (bus.err_clr) begin
         err_cnt <= '0;
      end else if (bit_err_d && (err_cnt != '1)) begin
         err_cnt <= err_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk_flag or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         locked_q      <= 1'b0;
         data_q        <= 1'b0;
         bit_err_q     <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         locked_q      <= locked_d;
         data_q        <= data_d;
         bit_err_q     <= bit_err_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign bus.locked      = locked_q;
   assign bus.inverted    = inv;
   assign bus.phase       = ptr;
   assign bus.data_out    = data_q;
   assign bus.bit_err     = bit_err_q;
   assign bus.frame_start = frame_start_q;
   assign bus.err_cnt     = err_cnt;

endmodule

// File: tb/tb_seq_checker.sv
// Bench for seq_checker: directed acquisition/lock scenarios plus randomized streams,
// all outputs compared every cycle against a bit-history reference model.
module tb_seq_checker;

   localparam int VLEN = 16;
   localparam int LTHR = 4;

   localparam int MD_HUNT  = 0;
   localparam int MD_CHECK = 1;
   localparam int MD_TRACK = 2;

   logic clk_flag  = 1'b0;
   logic sys_rst_n = 1'b1;

   seq_checker_if bus ();

   seq_checker #(
      .PATTERN    (16'hCBB2),
      .VERIFY_LEN (VLEN),
      .LOSS_THR   (LTHR)
   ) dut (
      .clk_flag  (clk_flag),
      .sys_rst_n (sys_rst_n),
      .bus       (bus)
   );

   always #5 clk_flag = ~clk_flag;

   int   n_chk  = 0;
   int   n_fail = 0;
   bit   chk_en = 1'b0;
   int   fs_seen = 0;
   logic [15:0] pat_v;

   int   m_mode, m_ptr, m_good, m_ferr, m_errs;
   bit   m_inv;
   logic hist[$];
   bit   e_locked, e_inv, e_data, e_berr, e_fs;
   int   e_phase, e_errcnt;

   int   tx_pos;
   bit   tx_inv;

   function automatic logic pbit(input int k);
      return pat_v[k % 16];
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_chk++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp_v, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = MD_HUNT; m_ptr = 0; m_good = 0; m_ferr = 0; m_errs = 0; m_inv = 1'b0;
      hist.delete();
      e_locked = 0; e_inv = 0; e_data = 0; e_berr = 0; e_fs = 0; e_phase = 0; e_errcnt = 0;
   endtask

   task automatic model_step(input logic b, input logic clr);
      bit found, ok, hp, err;
      int hr;
      found = 0; hr = 0; hp = 0;
      hist.push_back(b);
      if (hist.size() > 16) void'(hist.pop_front());
      e_data = b ^ m_inv;
      e_berr = 0;
      e_fs   = 0;
      case (m_mode)
         MD_HUNT: begin
            if (hist.size() == 16) begin
               for (int pol = 0; pol < 2; pol++)
                  for (int r = 0; r < 16; r++)
                     if (!found) begin
                        ok = 1;
                        for (int j = 0; j < 16; j++)
                           if (hist[j] !== (pbit(r + j) ^ logic'(pol))) ok = 0;
                        if (ok) begin found = 1; hr = r; hp = bit'(pol); end
                     end
               if (found) begin
                  m_mode = MD_CHECK; m_ptr = hr; m_inv = hp; m_good = 0;
               end
            end
         end
         MD_CHECK: begin
            if (b !== (pbit(m_ptr) ^ m_inv)) m_mode = MD_HUNT;
            else begin
               m_ptr  = (m_ptr + 1) % 16;
               m_good = m_good + 1;
               if (m_good == VLEN) begin m_mode = MD_TRACK; m_ferr = 0; end
            end
         end
         default: begin
            err    = (b !== (pbit(m_ptr) ^ m_inv));
            e_berr = err;
            e_fs   = (m_ptr == 0);
            if (err) begin
               m_ferr++;
               if (m_errs < 65535) m_errs++;
            end
            if (m_ptr == 15) begin
               if (m_ferr >= LTHR) m_mode = MD_HUNT;
               m_ferr = 0;
            end
            m_ptr = (m_ptr + 1) % 16;
         end
      endcase
      if (clr) m_errs = 0;
      e_locked = (m_mode == MD_TRACK);
      e_inv    = m_inv;
      e_phase  = m_ptr;
      e_errcnt = m_errs;
   endtask

   always @(negedge clk_flag) begin
      if (chk_en) begin
         chk("locked",      32'(bus.locked),      32'(e_locked));
         chk("inverted",    32'(bus.inverted),    32'(e_inv));
         chk("phase",       32'(bus.phase),       32'(e_phase));
         chk("data_out",    32'(bus.data_out),    32'(e_data));
         chk("bit_err",     32'(bus.bit_err),     32'(e_berr));
         chk("frame_start", 32'(bus.frame_start), 32'(e_fs));
         chk("err_cnt",     32'(bus.err_cnt),     32'(e_errcnt));
         if (bus.frame_start === 1'b1) fs_seen++;
      end
   end

   task automatic step(input logic b, input logic clr);
      @(negedge clk_flag);
      bus.rx_bit  = b;
      bus.err_clr = clr;
      @(posedge clk_flag);
      model_step(b, clr);
   endtask

   task automatic send(input int n);
      repeat (n) begin
         step(pbit(tx_pos) ^ tx_inv, 1'b0);
         tx_pos = (tx_pos + 1) % 16;
      end
   endtask

   task automatic send_err(input logic clr);
      step(~(pbit(tx_pos) ^ tx_inv), clr);
      tx_pos = (tx_pos + 1) % 16;
   endtask

   task automatic pulse_reset();
      @(posedge clk_flag);
      #3;
      sys_rst_n = 1'b0;
      model_reset();
      #1;
      chk("rst_locked",   32'(bus.locked),      32'd0);
      chk("rst_inverted", 32'(bus.inverted),    32'd0);
      chk("rst_phase",    32'(bus.phase),       32'd0);
      chk("rst_data",     32'(bus.data_out),    32'd0);
      chk("rst_bit_err",  32'(bus.bit_err),     32'd0);
      chk("rst_fs",       32'(bus.frame_start), 32'd0);
      chk("rst_err_cnt",  32'(bus.err_cnt),     32'd0);
      @(posedge clk_flag);
      #2;
      sys_rst_n = 1'b1;
   endtask

   initial begin
      pat_v       = 16'hCBB2;
      bus.rx_bit  = 1'b0;
      bus.err_clr = 1'b0;
      model_reset();
      pulse_reset();
      chk_en = 1'b1;

      // Clean stream from index 0
      tx_pos = 0; tx_inv = 0;
      send(31); #2;
      chk("t1_locked_e31", 32'(bus.locked), 32'd0);
      send(1); #2;
      chk("t1_locked_e32", 32'(bus.locked),   32'd1);
      chk("t1_inverted",   32'(bus.inverted), 32'd0);
      chk("t1_phase",      32'(bus.phase),    32'd0);
      chk("t1_err_cnt",    32'(bus.err_cnt),  32'd0);
      fs_seen = 0;
      send(32);
      chk("t1_fs_pulses", 32'(fs_seen), 32'd2);

      // Complemented stream from index 5
      pulse_reset();
      tx_pos = 5; tx_inv = 1;
      send(16); #2;
      chk("t2_inverted", 32'(bus.inverted), 32'd1);
      chk("t2_phase",    32'(bus.phase),    32'd5);
      chk("t2_unlocked", 32'(bus.locked),   32'd0);
      send(16); #2;
      chk("t2_locked",   32'(bus.locked),   32'd1);
      send(16); #2;
      chk("t2_data", 32'(bus.data_out), 32'(pbit(tx_pos + 15)));

      // Single error while locked
      send_err(1'b0); #2;
      chk("t3_bit_err", 32'(bus.bit_err), 32'd1);
      chk("t3_err_cnt", 32'(bus.err_cnt), 32'd1);
      send(1); #2;
      chk("t3_bit_err_off", 32'(bus.bit_err), 32'd0);
      send(20); #2;
      chk("t3_locked", 32'(bus.locked), 32'd1);

      // Four errors in one frame drop lock
      while (tx_pos != 0) send(1);
      for (int k = 0; k < 16; k++) begin
         if (k == 2 || k == 5 || k == 8 || k == 11) send_err(1'b0);
         else send(1);
      end
      #2;
      chk("t4_lost", 32'(bus.locked), 32'd0);
      send(48); #2;
      chk("t4_relock",  32'(bus.locked),  32'd1);
      chk("t4_err_cnt", 32'(bus.err_cnt), 32'd5);

      // Error on the 8th verify bit
      pulse_reset();
      tx_pos = int'($urandom_range(0, 15)); tx_inv = 0;
      send(16);
      send(7);
      send_err(1'b0); #2;
      chk("t5_unlocked", 32'(bus.locked), 32'd0);
      send(31); #2;
      chk("t5_still_unlocked", 32'(bus.locked), 32'd0);
      send(1); #2;
      chk("t5_locked", 32'(bus.locked), 32'd1);

      // err_clr wins over a same-cycle error, then async reset mid-lock
      send_err(1'b0);
      send(1); #2;
      chk("t6_err_cnt1", 32'(bus.err_cnt), 32'd1);
      send_err(1'b1); #2;
      chk("t6_err_clr", 32'(bus.err_cnt), 32'd0);
      chk("t6_berr",    32'(bus.bit_err), 32'd1);
      send(5);
      pulse_reset();
      send(31); #2;
      chk("t6_unlocked", 32'(bus.locked), 32'd0);
      send(1); #2;
      chk("t6_relocked", 32'(bus.locked), 32'd1);

      // Randomized streams: noise prefix, clean run, sparse errors and bursts
      for (int it = 0; it < 6; it++) begin
         pulse_reset();
         tx_pos = int'($urandom_range(0, 15));
         tx_inv = bit'($urandom_range(0, 1));
         repeat (int'($urandom_range(0, 20))) step(logic'($urandom_range(0, 1)), 1'b0);
         send(40);
         for (int n = 0; n < 140; n++) begin
            if ($urandom_range(0, 39) == 0) begin
               repeat (4) send_err(1'b0);
            end else if ($urandom_range(0, 14) == 0) begin
               send_err(logic'($urandom_range(0, 7) == 0));
            end else begin
               step(pbit(tx_pos) ^ tx_inv, logic'($urandom_range(0, 49) == 0));
               tx_pos = (tx_pos + 1) % 16;
            end
         end
      end

      @(negedge clk_flag);
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
